// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
// Signals:
//   in_data/in_valid  host -> loader stream byte and its qualifier
//   in_ready          loader -> host, byte accepted when in_valid & in_ready
//   imem_we/addr/wdata loader -> instruction memory, one strobe per word
// The loader uses the slave modport, the byte source / memory side the master.
interface imem_loader_if #(parameter int ADDR_W = 10);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   modport master (output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
   modport slave  (input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer fed by a framed byte stream.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          pulse starting a load from IDLE or ERR
//   bus            slave side of imem_loader_if (stream in, imem write out)
//   words_written  words written in the current load
//   cpu_hold       CPU stall until a checksum-verified image is loaded
//   done, error    sticky completion / failure flags
// Frame: len_hi, len_lo, 4*len data bytes (big-endian words), XOR checksum.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   imem_loader_if.slave      bus,
   output logic [ADDR_W:0]   words_written,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;
   localparam logic [16:0] DEPTH   = 17'(2 ** ADDR_W);

   logic [2:0]        state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [15:0]       len_q, len_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ADDR_W:0]   word_idx_q, word_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   ww_q, ww_d;
   logic              acc;
   logic [15:0]       len_in;
   logic [31:0]       next_word;
   logic [ADDR_W:0]   next_idx;

   assign bus.in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                         (state_q == S_DATA)   || (state_q == S_CSUM);
   assign acc          = bus.in_valid & bus.in_ready;
   assign len_in       = {len_hi_q, bus.in_data};
   assign next_word    = {word_q[23:0], bus.in_data};
   assign next_idx     = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign words_written  = ww_q;
   assign done           = state_q == S_DONE;
   assign error          = state_q == S_ERR;
   assign cpu_hold       = state_q != S_DONE;

   always_comb begin
      state_d    = state_q;
      len_hi_d   = len_hi_q;
      len_d      = len_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ww_d       = ww_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_LEN_HI : S_IDLE;
         S_LEN_HI: begin
            if (acc) begin
               len_hi_d = bus.in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (acc) begin
               if (len_in == 16'd0 || {1'b0, len_in} > DEPTH) begin
                  state_d = S_ERR;
               end else begin
                  len_d      = len_in;
                  byte_idx_d = 2'd0;
                  word_idx_d = '0;
                  csum_d     = 8'd0;
                  state_d    = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (acc) begin
               word_d     = next_word;
               csum_d     = csum_q ^ bus.in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Completed word: strobe lands in the following cycle while the stream keeps flowing.
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = word_idx_q[ADDR_W-1:0];
                  wdata_d    = next_word;
                  ww_d       = next_idx;
                  word_idx_d = next_idx;
                  if (16'(next_idx) == len_q) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (acc) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
         end
         S_ERR: begin
            if (start) begin
               state_d = S_LEN_HI;
               ww_d    = '0;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_hi_q   <= 8'd0;
         len_q      <= 16'd0;
         word_q     <= 32'd0;
         byte_idx_q <= 2'd0;
         word_idx_q <= '0;
         csum_q     <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         ww_q       <= '0;
      end else begin
         state_q    <= state_d;
         len_hi_q   <= len_hi_d;
         len_q      <= len_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ww_q       <= ww_d;
      end
   end
endmodule
